// File: rtl/ofdm_rx_frame_ctrl.sv
// Frame sequencer for the OFDM receive chain: init pulse, symbol search, bit/symbol
// counting, sample strobe generation and a progress watchdog.
module ofdm_rx_frame_ctrl #(
  parameter int unsigned raw_symbol_length_g = 64,
  parameter int unsigned symbols_per_frame_g = 12,
  parameter int unsigned strobe_div_g        = 25,
  parameter int unsigned timeout_g           = 400000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sym_start,
  input  logic        rcv_data_valid,
  output logic        sample_strobe,
  output logic        rx_sys_init,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] bit_cnt,
  output logic [7:0]  sym_cnt
);

  localparam int unsigned SB_W = $clog2(raw_symbol_length_g + 1);
  localparam int unsigned WD_W = $clog2(timeout_g + 1);
  localparam int unsigned ST_W = $clog2(strobe_div_g);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SEARCH,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_bit_cnt;
  logic [7:0]        r_sym_cnt;
  logic [SB_W-1:0]   r_sym_bits;
  logic [SB_W-1:0]   w_sym_bits_inc;
  logic [WD_W-1:0]   r_wdog;
  logic [ST_W-1:0]   r_strb;
  logic              r_strobe;
  logic              r_init;
  logic              r_busy;
  logic              r_done;
  logic              r_terr;
  logic              w_active;
  logic              w_progress;
  logic              w_frame_done;
  logic              w_timeout;
  logic              w_rx_pulse;
  logic              w_sym_wrap;
  logic              w_strb_run;

  always_comb begin
    w_active       = (r_state == S_SEARCH) || (r_state == S_RECEIVE);
    w_progress     = w_active && (sym_start || rcv_data_valid);
    w_frame_done   = (r_state == S_RECEIVE) && (r_sym_cnt == 8'(symbols_per_frame_g));
    // Timeout loses to both abort and frame completion in the same cycle.
    w_timeout      = w_active && !w_progress && (r_wdog == WD_W'(timeout_g - 1))
                     && !w_frame_done && !abort;
    w_rx_pulse     = (r_state == S_RECEIVE) && rcv_data_valid && !w_frame_done;
    w_sym_bits_inc = r_sym_bits + SB_W'(2);
    w_sym_wrap     = (w_sym_bits_inc >= SB_W'(raw_symbol_length_g));

    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_INIT;
      S_INIT:    w_next = S_SEARCH;
      S_SEARCH:  if (sym_start) w_next = S_RECEIVE;
      S_RECEIVE: if (w_frame_done) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;

    w_strb_run = w_active && ((w_next == S_SEARCH) || (w_next == S_RECEIVE));
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_init     <= 1'b0;
      r_strobe   <= 1'b0;
      r_strb     <= '0;
      r_wdog     <= '0;
      r_terr     <= 1'b0;
      r_bit_cnt  <= '0;
      r_sym_cnt  <= '0;
      r_sym_bits <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_init  <= (w_next == S_INIT);

      if (w_strb_run) begin
        if (r_strb == ST_W'(strobe_div_g - 1)) begin
          r_strb   <= '0;
          r_strobe <= 1'b1;
        end else begin
          r_strb   <= r_strb + 1'b1;
          r_strobe <= 1'b0;
        end
      end else begin
        r_strb   <= '0;
        r_strobe <= 1'b0;
      end

      r_wdog <= (w_active && (w_next == r_state) && !w_progress) ? r_wdog + 1'b1 : '0;

      if (w_next == S_INIT) begin
        r_bit_cnt  <= '0;
        r_sym_cnt  <= '0;
        r_sym_bits <= '0;
        r_terr     <= 1'b0;
      end else begin
        if (w_timeout) r_terr <= 1'b1;
        if (w_rx_pulse) begin
          r_bit_cnt <= (r_bit_cnt >= 16'hFFFE) ? 16'hFFFF : r_bit_cnt + 16'd2;
          if (w_sym_wrap) begin
            r_sym_bits <= '0;
            r_sym_cnt  <= r_sym_cnt + 8'd1;
          end else begin
            r_sym_bits <= w_sym_bits_inc;
          end
        end
      end
    end
  end

  assign sample_strobe = r_strobe;
  assign rx_sys_init   = r_init;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_terr;
  assign bit_cnt       = r_bit_cnt;
  assign sym_cnt       = r_sym_cnt;

endmodule

// File: tb/tb_ofdm_rx_frame_ctrl.sv
// Randomized bench for ofdm_rx_frame_ctrl; expectations come from frame-level arithmetic
// over the stimulus timeline (pulse counts, strobe grid, timeout distance).
module tb_ofdm_rx_frame_ctrl;

  localparam int unsigned RAW          = 64;
  localparam int unsigned SPF          = 12;
  localparam int unsigned DIV          = 25;
  localparam int unsigned TMO          = 1000;
  localparam int unsigned FRAME_PULSES = SPF * RAW / 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        abort;
  logic        sym_start;
  logic        rcv_data_valid;
  logic        sample_strobe;
  logic        rx_sys_init;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] bit_cnt;
  logic [7:0]  sym_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned done_tot = 0;
  int unsigned init_tot = 0;
  int unsigned strb_q[$];

  ofdm_rx_frame_ctrl #(
    .raw_symbol_length_g(RAW),
    .symbols_per_frame_g(SPF),
    .strobe_div_g       (DIV),
    .timeout_g          (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .abort         (abort),
    .sym_start     (sym_start),
    .rcv_data_valid(rcv_data_valid),
    .sample_strobe (sample_strobe),
    .rx_sys_init   (rx_sys_init),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .bit_cnt       (bit_cnt),
    .sym_cnt       (sym_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (sys_rst === 1'b0) begin
      if (sample_strobe) strb_q.push_back(cyc);
      if (done) done_tot++;
      if (rx_sys_init) init_tot++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  // Strobes land on a DIV-cycle grid from SEARCH entry while still in SEARCH/RECEIVE.
  task automatic chk_strobes(input int unsigned q0, input int unsigned entry,
                             input int unsigned last_sr);
    int unsigned n_exp;
    int unsigned n_got;
    n_exp = (last_sr - entry) / DIV;
    n_got = strb_q.size() - q0;
    chk("strobe_count", n_got, n_exp);
    for (int unsigned k = 0; k < n_exp && k < n_got; k++)
      chk("strobe_pos", strb_q[q0 + k] - entry, DIV * (k + 1));
  endtask

  task automatic run_frame(input int unsigned sym_delay, input int unsigned npulse,
                           input int unsigned abort_at, input int unsigned max_gap);
    int unsigned s, entry, p_edge, last_sr, counted, lim, d0, i0, q0;
    d0 = done_tot;
    i0 = init_tot;
    q0 = strb_q.size();
    step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("init_pulse", rx_sys_init, 1);
    chk("init_bits", bit_cnt, 0);
    chk("init_syms", sym_cnt, 0);
    chk("init_terr", timeout_err, 0);
    chk("init_busy", busy, 1);
    entry = s + 2;
    while (cyc < entry + sym_delay - 1) begin
      rcv_data_valid = ($urandom_range(0, 7) == 0);
      step();
    end
    rcv_data_valid = 1'b0;
    sym_start = 1'b1;
    step();
    sym_start = 1'b0;
    lim = (abort_at != 0) ? abort_at : FRAME_PULSES;
    counted = lim;
    p_edge = 0;
    for (int unsigned i = 1; i <= npulse; i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      rcv_data_valid = 1'b1;
      abort = (i == abort_at);
      start = (i < lim) && ($urandom_range(0, 15) == 0);
      if (i == lim) p_edge = cyc + 1;
      step();
      rcv_data_valid = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      if (i == abort_at) break;
    end
    last_sr = (abort_at != 0) ? p_edge - 1 : p_edge;
    repeat (5) step();
    chk("bit_cnt", bit_cnt, 2 * counted);
    chk("sym_cnt", sym_cnt, (2 * counted) / RAW);
    chk("done_pulses", done_tot - d0, (abort_at != 0) ? 0 : 1);
    chk("init_pulses", init_tot - i0, 1);
    chk("busy_after", busy, 0);
    chk("terr_after", timeout_err, 0);
    chk_strobes(q0, entry, last_sr);
  endtask

  task automatic run_timeout();
    int unsigned s, entry, d0, q0;
    d0 = done_tot;
    q0 = strb_q.size();
    step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    entry = s + 2;
    while (cyc < entry + TMO - 1) step();
    chk("tmo_busy_before", busy, 1);
    chk("tmo_terr_before", timeout_err, 0);
    step();
    chk("tmo_busy", busy, 0);
    chk("tmo_terr", timeout_err, 1);
    chk("tmo_bits", bit_cnt, 0);
    repeat (3) step();
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_no_done", done_tot - d0, 0);
    chk("tmo_strobes", strb_q.size() - q0, (TMO - 1) / DIV);
  endtask

  task automatic run_reset_mid_frame();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    sym_start = 1'b1;
    step();
    sym_start = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      rcv_data_valid = 1'b1;
      step();
      rcv_data_valid = 1'b0;
      step();
    end
    chk("rst_pre_bits", bit_cnt, 200);
    chk("rst_pre_syms", sym_cnt, 200 / RAW);
    chk("rst_pre_busy", busy, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bits", bit_cnt, 0);
    chk("rst_syms", sym_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_init", rx_sys_init, 0);
    chk("rst_terr", timeout_err, 0);
    step();
    sys_rst = 1'b0;
    repeat (10) step();
    chk("rst_stays_idle", busy, 0);
  endtask

  initial begin
    int unsigned ab;
    sys_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sym_start = 1'b0;
    rcv_data_valid = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_bits", bit_cnt, 0);
    chk("reset_syms", sym_cnt, 0);
    chk("reset_terr", timeout_err, 0);
    sys_rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    run_frame(100, FRAME_PULSES, 0, 0);
    run_frame(20, FRAME_PULSES, FRAME_PULSES, 2);
    run_timeout();
    run_frame(37, FRAME_PULSES + 3, 0, 3);
    run_reset_mid_frame();
    run_frame(5, FRAME_PULSES, 0, 1);

    for (int unsigned f = 0; f < 4; f++) begin
      ab = ($urandom_range(0, 1) != 0) ? $urandom_range(1, FRAME_PULSES) : 0;
      run_frame($urandom_range(1, 150), FRAME_PULSES + $urandom_range(0, 4), ab, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
